seq_divider: RTL and testbench

Unsigned sequential radix-2 restoring divider. It is the inverse-arithmetic companion to the matrix datapath's adder/multiplier chain, and is used to normalise and scale accumulated matrix results.
- One quotient bit is produced per cycle using a trial subtraction (borrow-detect adder).
- Valid/ready handshakes are used on both input and output.
- Only one division is in flight at a time.

---
 rtl/seq_divider.sv | 118 +++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, valid/ready on both sides.
// A zero divisor short-circuits straight to a flagged all-ones result.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_t;
    logic             w_qbit;

    // The shifted-out MSB of R stays as bit WIDTH so MSB-set divisors compare correctly.
    assign w_s    = {r_r, r_q[WIDTH-1]};
    assign w_t    = w_s - {1'b0, r_div};
    assign w_qbit = ~w_t[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_div <= divisor;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            r_q   <= '1;
                            r_r   <= dividend;
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= dividend;
                            r_r   <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_r <= w_qbit ? w_t[WIDTH-1:0] : w_s[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], w_qbit};
                    // Saturate so the counter never wraps after the final step.
                    if (r_cnt != LAST) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider at WIDTH=16.
module tb_seq_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; returns in cycle 1 with the inputs scrambled.
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        chk("in_ready_before_accept", 64'(in_ready), 64'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = b + W'(1);
    endtask

    task automatic wait_valid(input int budget, output int lat, output bit low_ok);
        lat    = 1;
        low_ok = 1'b1;
        while (!out_valid && lat < budget) begin
            if (in_ready) low_ok = 1'b0;
            tick();
            lat++;
        end
        if (in_ready) low_ok = 1'b0;
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'(1));
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edbz, input int elat);
        int lat;
        bit low_ok;
        start_div(a, b);
        wait_valid(60, lat, low_ok);
        $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0b at cycle %0d",
                 tag, a, b, quotient, remainder, div_by_zero, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
        chk({tag, "_remainder"}, 64'(remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        chk({tag, "_in_ready_low"}, 64'(low_ok), 64'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'(0));
    endtask

    int           lat_bp;
    bit           low_bp;
    bit           seen_valid;
    logic [W-1:0] ra, rb, rq, rr;
    logic         rd;
    bit           got, done, stable;
    int           cyc;

    initial begin
        tick();
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_quotient", 64'(quotient), 64'(0));
        chk("reset_remainder", 64'(remainder), 64'(0));
        chk("reset_dbz", 64'(div_by_zero), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        run_div("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
        run_div("ffff_8001", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 17);
        run_div("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17);
        run_div("d0_3", 16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 17);
        run_div("d1234_0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
        run_div("d10_3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 17);

        // Hold the result under backpressure while offering a competing request.
        start_div(16'd200, 16'd13);
        wait_valid(60, lat_bp, low_bp);
        $display("bp: 200 / 13 -> q=%0d r=%0d at cycle %0d", quotient, remainder, lat_bp);
        chk("bp_latency", 64'(lat_bp), 64'(17));
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_quotient", 64'(quotient), 64'(15));
            chk("bp_remainder", 64'(remainder), 64'(5));
            chk("bp_dbz", 64'(div_by_zero), 64'(0));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            in_valid = 1'b1;
            dividend = 16'd1;
            divisor  = 16'd1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after", 64'(in_ready), 64'(1));
        chk("bp_out_valid_after", 64'(out_valid), 64'(0));

        // Abort mid-calculation with a one-cycle reset at cycle 8.
        start_div(16'd60000, 16'd7);
        repeat (7) tick();
        chk("abort_busy", 64'(in_ready), 64'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        seen_valid = 1'b0;
        repeat (25) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        chk("abort_no_result", 64'(seen_valid), 64'(0));
        $display("abort: 60000 / 7 discarded by reset");
        run_div("d60000_7", 16'd60000, 16'd7, 16'd8571, 16'd3, 1'b0, 17);

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom_range(1, 65535));
            endcase
            start_div(ra, rb);
            got = 1'b0;
            done = 1'b0;
            stable = 1'b1;
            cyc = 0;
            rq = '0;
            rr = '0;
            rd = 1'b0;
            while (!done && cyc < 60) begin
                if (out_valid) begin
                    if (got && (quotient !== rq || remainder !== rr || div_by_zero !== rd))
                        stable = 1'b0;
                    rq  = quotient;
                    rr  = remainder;
                    rd  = div_by_zero;
                    got = 1'b1;
                end
                out_ready = 1'($urandom_range(0, 1));
                done = out_valid && out_ready;
                tick();
                cyc++;
            end
            out_ready = 1'b0;
            $display("rand %0d: %0d / %0d -> q=%0d r=%0d dbz=%0b", n, ra, rb, rq, rr, rd);
            chk("rand_done", 64'(done), 64'(1));
            chk("rand_stable", 64'(stable), 64'(1));
            if (rb != '0) begin
                chk("rand_recon", 64'(rq) * 64'(rb) + 64'(rr), 64'(ra));
                chk("rand_rem_lt_div", 64'(rr < rb), 64'(1));
                chk("rand_dbz", 64'(rd), 64'(0));
            end else begin
                chk("rand_z_quotient", 64'(rq), 64'hFFFF);
                chk("rand_z_remainder", 64'(rr), 64'(ra));
                chk("rand_z_dbz", 64'(rd), 64'(1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
